// File: rtl/mfp_ahb_lite_timer_pkg.sv
// Shared definitions for the AHB-Lite timer/compare peripheral.
// Includes the register offsets, CTRL bit positions, reset values,
// the matrix-side address-match constant and the byte-lane helpers.
package mfp_ahb_lite_timer_pkg;

    // Register index, taken from HADDR[3:2]
    typedef enum logic [1:0] {
        TIMER_CTRL    = 2'd0,
        TIMER_COUNT   = 2'd1,
        TIMER_COMPARE = 2'd2,
        TIMER_STATUS  = 2'd3
    } timer_reg_e;

    // CTRL bit positions
    localparam int unsigned CTRL_EN           = 0;
    localparam int unsigned CTRL_AUTO_RELOAD  = 1;
    localparam int unsigned CTRL_IE           = 2;
    localparam int unsigned CTRL_PRESCALE_LSB = 8;
    localparam int unsigned CTRL_PRESCALE_MSB = 15;

    // STATUS bit positions
    localparam int unsigned STATUS_MATCH = 0;

    localparam logic [31:0] TIMER_COMPARE_RESET = 32'hFFFF_FFFF;

    // Matrix decoder compares HADDR[31:12] against this for the 4 KB slot
    // at physical 0x1040_3000.
    localparam logic [19:0] MFP_TIMER_ADDR_MATCH = 20'h10403;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;

    // Byte lanes touched by a transfer of the given size at addr[1:0].
    // Anything wider than a halfword is treated as a full word.
    function automatic logic [3:0] byte_lanes(input logic [2:0] size,
                                              input logic [1:0] addr);
        logic [3:0] lanes;
        lanes = 4'b1111;
        if (size == HSIZE_BYTE) begin
            lanes = 4'b0001 << addr;
        end else if (size == HSIZE_HALF) begin
            lanes = addr[1] ? 4'b1100 : 4'b0011;
        end
        return lanes;
    endfunction

    // Expand per-lane enables to a 32-bit bit mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] lanes);
        return {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
    endfunction

endpackage

// File: rtl/mfp_timer_prescaler.sv
// Prescale divider for the timer.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   enable    - counter runs only while high; held at zero otherwise
//   clear     - synchronously restarts the divide period
//   divider   - tick period is divider+1 cycles
//   tick      - one-cycle strobe when the counter reaches divider
module mfp_timer_prescaler
    #(
        parameter int unsigned PRESCALE_WIDTH = 8
    )
    (
        input  logic                      clk,
        input  logic                      rst,
        input  logic                      enable,
        input  logic                      clear,
        input  logic [PRESCALE_WIDTH-1:0] divider,
        output logic                      tick
    );

    logic [PRESCALE_WIDTH-1:0] pcnt_q;
    logic [PRESCALE_WIDTH-1:0] pcnt_d;

    always_comb begin
        tick = enable && (pcnt_q == divider);
        if (!enable || clear || tick) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + PRESCALE_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/mfp_ahb_lite_timer.sv
// AHB-Lite timer/compare slave.
// 32-bit up-counter with prescaler, compare register, sticky match flag
// and a level interrupt (MATCH & IE) toward the EIC.
// Ports:
//   HCLK, HRESET         - clock, asynchronous active-high reset
//   HADDR..HWRITE        - AHB-Lite slave inputs (HBURST, HMASTLOCK, HPROT ignored)
//   HRDATA/HREADY/HRESP  - response; zero wait states, always OKAY
//   SI_Endian            - ignored, lanes are little-endian
//   TIMER_INT            - level interrupt
module mfp_ahb_lite_timer
    import mfp_ahb_lite_timer_pkg::*;
    #(
        parameter int unsigned PRESCALE_WIDTH = 8,
        parameter int unsigned COUNT_WIDTH    = 32
    )
    (
        input  logic        HCLK,
        input  logic        HRESET,
        input  logic [31:0] HADDR,
        input  logic [2:0]  HBURST,
        input  logic        HMASTLOCK,
        input  logic [3:0]  HPROT,
        input  logic        HSEL,
        input  logic [2:0]  HSIZE,
        input  logic [1:0]  HTRANS,
        input  logic [31:0] HWDATA,
        input  logic        HWRITE,
        output logic [31:0] HRDATA,
        output logic        HREADY,
        output logic        HRESP,
        input  logic        SI_Endian,
        output logic        TIMER_INT
    );

    // Writable CTRL bits: EN, AUTO_RELOAD, IE and the prescale field
    localparam logic [31:0] CTRL_WMASK =
        32'h0000_0007 | (((32'h1 << PRESCALE_WIDTH) - 32'h1) << CTRL_PRESCALE_LSB);

    // Address-phase latch
    logic       dp_valid_q, dp_valid_d;
    logic       dp_write_q, dp_write_d;
    logic [3:0] dp_addr_q,  dp_addr_d;
    logic [2:0] dp_size_q,  dp_size_d;

    // Registers
    logic [31:0]            ctrl_q,    ctrl_d;
    logic [COUNT_WIDTH-1:0] count_q,   count_d;
    logic [COUNT_WIDTH-1:0] compare_q, compare_d;
    logic                   match_q,   match_d;

    timer_reg_e  dp_reg;
    logic [31:0] wmask;
    logic        wr_active;
    logic        count_wr;
    logic        status_w1c;
    logic        tick;
    logic        hit;
    logic        unused_inputs;

    always_comb begin
        unused_inputs = ^{HADDR[31:4], HBURST, HMASTLOCK, HPROT, HTRANS[0], SI_Endian};
    end

    // Address phase
    always_comb begin
        dp_valid_d = 1'b0;
        dp_write_d = 1'b0;
        dp_addr_d  = '0;
        dp_size_d  = '0;
        if (HSEL && HTRANS[1]) begin
            dp_valid_d = 1'b1;
            dp_write_d = HWRITE;
            dp_addr_d  = HADDR[3:0];
            dp_size_d  = HSIZE;
        end
    end

    // Data-phase decode
    always_comb begin
        dp_reg     = timer_reg_e'(dp_addr_q[3:2]);
        wmask      = lane_mask(byte_lanes(dp_size_q, dp_addr_q[1:0]));
        wr_active  = dp_valid_q && dp_write_q;
        count_wr   = wr_active && (dp_reg == TIMER_COUNT);
        status_w1c = wr_active && (dp_reg == TIMER_STATUS)
                     && wmask[STATUS_MATCH] && HWDATA[STATUS_MATCH];
    end

    mfp_timer_prescaler #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_prescaler (
        .clk     (HCLK),
        .rst     (HRESET),
        .enable  (ctrl_q[CTRL_EN]),
        .clear   (count_wr),
        .divider (ctrl_q[CTRL_PRESCALE_LSB +: PRESCALE_WIDTH]),
        .tick    (tick)
    );

    // Register next-state. The compare uses the pre-write COMPARE value, and a
    // COUNT write is applied after the tick update so it takes priority.
    always_comb begin
        hit       = tick && (count_q == compare_q);
        ctrl_d    = ctrl_q;
        count_d   = count_q;
        compare_d = compare_q;
        match_d   = (match_q && !status_w1c) || hit;

        if (tick) begin
            if (hit && ctrl_q[CTRL_AUTO_RELOAD]) begin
                count_d = '0;
            end else begin
                count_d = count_q + COUNT_WIDTH'(1);
            end
        end

        if (wr_active) begin
            case (dp_reg)
                TIMER_CTRL:    ctrl_d    = ((ctrl_q & ~wmask) | (HWDATA & wmask)) & CTRL_WMASK;
                TIMER_COUNT:   count_d   = (count_q & ~wmask) | (HWDATA & wmask);
                TIMER_COMPARE: compare_d = (compare_q & ~wmask) | (HWDATA & wmask);
                TIMER_STATUS:  ;
            endcase
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_addr_q  <= '0;
            dp_size_q  <= '0;
            ctrl_q     <= '0;
            count_q    <= '0;
            compare_q  <= TIMER_COMPARE_RESET;
            match_q    <= 1'b0;
        end else begin
            dp_valid_q <= dp_valid_d;
            dp_write_q <= dp_write_d;
            dp_addr_q  <= dp_addr_d;
            dp_size_q  <= dp_size_d;
            ctrl_q     <= ctrl_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            match_q    <= match_d;
        end
    end

    // Response path
    always_comb begin
        HRDATA = '0;
        if (dp_valid_q && !dp_write_q) begin
            case (dp_reg)
                TIMER_CTRL:    HRDATA = ctrl_q;
                TIMER_COUNT:   HRDATA = count_q;
                TIMER_COMPARE: HRDATA = compare_q;
                TIMER_STATUS:  HRDATA = {31'b0, match_q};
            endcase
        end
        HREADY    = 1'b1;
        HRESP     = 1'b0;
        TIMER_INT = match_q && ctrl_q[CTRL_IE];
    end

endmodule

// File: tb/tb_mfp_ahb_lite_timer.sv
module tb_mfp_ahb_lite_timer;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic [31:0] HADDR = '0;
    logic [2:0]  HBURST = '0;
    logic        HMASTLOCK = 1'b0;
    logic [3:0]  HPROT = '0;
    logic        HSEL = 1'b0;
    logic [2:0]  HSIZE = '0;
    logic [1:0]  HTRANS = '0;
    logic [31:0] HWDATA = '0;
    logic        HWRITE = 1'b0;
    logic        SI_Endian = 1'b0;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic        TIMER_INT;

    int n_tests = 0;
    int n_fail  = 0;
    logic [27:0] addr_hi = 28'h1040300;

    always #5 HCLK = ~HCLK;

    mfp_ahb_lite_timer #(
        .PRESCALE_WIDTH (8),
        .COUNT_WIDTH    (32)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HADDR     (HADDR),
        .HBURST    (HBURST),
        .HMASTLOCK (HMASTLOCK),
        .HPROT     (HPROT),
        .HSEL      (HSEL),
        .HSIZE     (HSIZE),
        .HTRANS    (HTRANS),
        .HWDATA    (HWDATA),
        .HWRITE    (HWRITE),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP),
        .SI_Endian (SI_Endian),
        .TIMER_INT (TIMER_INT)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_ctrl, m_count, m_compare;
    logic        m_match;
    logic [7:0]  m_phase;
    logic        p_valid, p_write;
    logic [3:0]  p_addr;
    logic [2:0]  p_size;

    function automatic bit m_tick();
        return m_ctrl[0] && (m_phase == m_ctrl[15:8]);
    endfunction

    function automatic bit m_hit();
        return m_tick() && (m_count == m_compare);
    endfunction

    function automatic bit m_writes(input int idx);
        return p_valid && p_write && (int'(p_addr[3:2]) == idx);
    endfunction

    // Replace the bytes covered by the pending transfer: a transfer of 2^size
    // bytes starts at the address rounded down to its own size.
    function automatic logic [31:0] m_merge(input logic [31:0] old);
        logic [31:0] r;
        int nb, first;
        r = old;
        nb = 1 << p_size;
        first = (int'(p_addr[1:0]) / nb) * nb;
        for (int b = first; b < first + nb; b++) r[8*b +: 8] = HWDATA[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_next_count();
        if (m_writes(1)) return m_merge(m_count);
        if (!m_tick()) return m_count;
        if (m_hit() && m_ctrl[1]) return 32'h0;
        return m_count + 32'h1;
    endfunction

    function automatic logic [7:0] m_next_phase();
        if (!m_ctrl[0] || m_writes(1) || m_tick()) return 8'h0;
        return m_phase + 8'h1;
    endfunction

    function automatic logic m_next_match();
        if (m_hit()) return 1'b1;
        if (m_writes(3) && (p_size == 3'd2 || p_addr[1:0] == 2'd0) && HWDATA[0]) return 1'b0;
        return m_match;
    endfunction

    function automatic logic [31:0] m_rdata();
        if (!p_valid || p_write) return 32'h0;
        case (p_addr[3:2])
            2'd0: return m_ctrl;
            2'd1: return m_count;
            2'd2: return m_compare;
            default: return {31'b0, m_match};
        endcase
    endfunction

    always @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            m_ctrl    <= 32'h0;
            m_count   <= 32'h0;
            m_compare <= 32'hFFFF_FFFF;
            m_match   <= 1'b0;
            m_phase   <= 8'h0;
            p_valid   <= 1'b0;
            p_write   <= 1'b0;
            p_addr    <= 4'h0;
            p_size    <= 3'h0;
        end else begin
            m_ctrl    <= m_writes(0) ? (m_merge(m_ctrl) & 32'h0000_FF07) : m_ctrl;
            m_compare <= m_writes(2) ? m_merge(m_compare) : m_compare;
            m_count   <= m_next_count();
            m_match   <= m_next_match();
            m_phase   <= m_next_phase();
            p_valid   <= HSEL && HTRANS[1];
            p_write   <= HSEL && HTRANS[1] && HWRITE;
            p_addr    <= (HSEL && HTRANS[1]) ? HADDR[3:0] : 4'h0;
            p_size    <= (HSIZE > 3'd2) ? 3'd2 : HSIZE;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // One bus cycle: drives the address phase and the write data of the
    // previous address phase.
    task automatic bus(input logic sel, input logic [1:0] tr, input logic wr,
                       input logic [3:0] a, input logic [2:0] sz, input logic [31:0] wd);
        @(posedge HCLK);
        #1;
        HSEL = sel; HTRANS = tr; HWRITE = wr;
        HADDR = {addr_hi, a}; HSIZE = sz; HWDATA = wd;
    endtask

    task automatic idle();
        bus(1'b0, 2'b00, 1'b0, 4'h0, 3'd0, 32'h0);
    endtask

    // Leaves the data phase in progress; it commits on the next edge.
    task automatic ahb_write(input logic [3:0] a, input logic [2:0] sz, input logic [31:0] d);
        bus(1'b1, 2'b10, 1'b1, a, sz, 32'h0);
        bus(1'b0, 2'b00, 1'b0, 4'h0, 3'd0, d);
    endtask

    task automatic ahb_read(input logic [3:0] a, output logic [31:0] d);
        bus(1'b1, 2'b10, 1'b0, a, 3'd2, 32'h0);
        idle();
        @(negedge HCLK);
        d = HRDATA;
    endtask

    task automatic do_reset();
        @(posedge HCLK);
        #3;
        HRESET = 1'b1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
        #4;
        HRESET = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  addr;
        logic [2:0]  size;
        logic [31:0] pre;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] exp_cnt;
        bit          prev_w;
        int          prev_idx;
        logic [31:0] wd;

        vecs[0]  = '{4'h8, 3'd2, 32'h1122_3344, 32'hCAFE_F00D, 32'hCAFE_F00D};
        vecs[1]  = '{4'h9, 3'd0, 32'h1122_3344, 32'hDEAD_ABEF, 32'h1122_AB44};
        vecs[2]  = '{4'h8, 3'd0, 32'h1122_3344, 32'h1234_5699, 32'h1122_3399};
        vecs[3]  = '{4'hB, 3'd0, 32'h1122_3344, 32'h7766_5544, 32'h7722_3344};
        vecs[4]  = '{4'hA, 3'd1, 32'h1122_3344, 32'hBEEF_0000, 32'hBEEF_3344};
        vecs[5]  = '{4'h6, 3'd1, 32'h0000_1234, 32'hBEEF_5678, 32'hBEEF_1234};
        vecs[6]  = '{4'h4, 3'd1, 32'hAAAA_5555, 32'h1234_C0DE, 32'hAAAA_C0DE};
        vecs[7]  = '{4'h0, 3'd2, 32'h0000_0000, 32'hFFFF_FFF8, 32'h0000_FF00};
        vecs[8]  = '{4'h1, 3'd0, 32'h0000_0000, 32'h0000_AB00, 32'h0000_AB00};
        vecs[9]  = '{4'h2, 3'd0, 32'h0000_0000, 32'h00FF_0000, 32'h0000_0000};
        vecs[10] = '{4'hC, 3'd2, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000};

        // ---- reset state ----
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        check("rst_hrdata", HRDATA, 32'h0);
        check("rst_int", {31'b0, TIMER_INT}, 32'h0);
        check("rst_hready", {31'b0, HREADY}, 32'h1);
        check("rst_hresp", {31'b0, HRESP}, 32'h0);
        #3 HRESET = 1'b0;
        ahb_read(4'h0, rd); check("rst_ctrl", rd, 32'h0);
        ahb_read(4'h4, rd); check("rst_count", rd, 32'h0);
        ahb_read(4'h8, rd); check("rst_compare", rd, 32'hFFFF_FFFF);
        ahb_read(4'hC, rd); check("rst_status", rd, 32'h0);

        // dirty the registers and raise the interrupt, then pulse reset mid-cycle
        ahb_write(4'h8, 3'd2, 32'h2);
        ahb_write(4'h0, 3'd2, 32'h7);
        repeat (6) idle();
        @(negedge HCLK);
        check("pre_pulse_int", {31'b0, TIMER_INT}, 32'h1);
        do_reset();
        #1;
        check("pulse_int", {31'b0, TIMER_INT}, 32'h0);
        check("pulse_hready", {31'b0, HREADY}, 32'h1);
        ahb_read(4'h0, rd); check("pulse_ctrl", rd, 32'h0);
        ahb_read(4'h4, rd); check("pulse_count", rd, 32'h0);
        ahb_read(4'h8, rd); check("pulse_compare", rd, 32'hFFFF_FFFF);
        ahb_read(4'hC, rd); check("pulse_status", rd, 32'h0);

        // reset during a write data phase aborts the write
        bus(1'b1, 2'b10, 1'b1, 4'h8, 3'd2, 32'h0);
        bus(1'b0, 2'b00, 1'b0, 4'h0, 3'd0, 32'h1234);
        #2 HRESET = 1'b1;
        @(posedge HCLK);
        #3 HRESET = 1'b0;
        ahb_read(4'h8, rd); check("abort_compare", rd, 32'hFFFF_FFFF);

        // ---- table: byte-lane writes and readback ----
        for (int i = 0; i < 11; i++) begin
            ahb_write(vecs[i].addr & 4'hC, 3'd2, vecs[i].pre);
            ahb_write(vecs[i].addr, vecs[i].size, vecs[i].wdata);
            ahb_read(vecs[i].addr & 4'hC, rd);
            check($sformatf("lane_vec%0d", i), rd, vecs[i].exp);
        end

        // ---- compare/auto-reload sequence ----
        do_reset();
        ahb_write(4'h8, 3'd2, 32'h5);
        bus(1'b1, 2'b10, 1'b1, 4'h0, 3'd2, 32'h0);
        bus(1'b1, 2'b10, 1'b0, 4'h4, 3'd2, 32'h7);
        for (int k = 0; k < 8; k++) begin
            bus(1'b1, 2'b10, 1'b0, 4'h4, 3'd2, 32'h0);
            @(negedge HCLK);
            check($sformatf("auto_count%0d", k), HRDATA, (k < 6) ? k : k - 6);
            check($sformatf("auto_int%0d", k), {31'b0, TIMER_INT}, (k >= 6) ? 32'h1 : 32'h0);
        end
        bus(1'b1, 2'b10, 1'b1, 4'hC, 3'd2, 32'h0);
        bus(1'b1, 2'b10, 1'b0, 4'hC, 3'd2, 32'h1);
        idle();
        @(negedge HCLK);
        check("w1c_status", HRDATA, 32'h0);
        check("w1c_int", {31'b0, TIMER_INT}, 32'h0);

        // ---- prescaler = 3 ----
        do_reset();
        ahb_write(4'h0, 3'd2, 32'h0000_0301);
        bus(1'b1, 2'b10, 1'b0, 4'h4, 3'd2, 32'h0);
        for (int n = 1; n <= 40; n++) begin
            bus(1'b1, 2'b10, 1'b0, 4'h4, 3'd2, 32'h0);
            @(negedge HCLK);
            if (n == 3 || n == 4 || n == 40)
                check($sformatf("presc_n%0d", n), HRDATA, n / 4);
        end
        ahb_write(4'h0, 3'd2, 32'h0000_0300);
        repeat (10) idle();
        ahb_read(4'h4, rd); check("freeze_count", rd, 32'd10);
        repeat (7) idle();
        ahb_read(4'h4, rd); check("freeze_count2", rd, 32'd10);

        // ---- wrap ----
        do_reset();
        ahb_write(4'h8, 3'd2, 32'h10);
        ahb_write(4'h4, 3'd2, 32'hFFFF_FFFE);
        bus(1'b1, 2'b10, 1'b1, 4'h0, 3'd2, 32'h0);
        bus(1'b1, 2'b10, 1'b0, 4'h4, 3'd2, 32'h5);
        for (int k = 0; k < 20; k++) begin
            bus(1'b1, 2'b10, 1'b0, 4'h4, 3'd2, 32'h0);
            @(negedge HCLK);
            exp_cnt = 32'hFFFF_FFFE + k;
            check($sformatf("wrap_count%0d", k), HRDATA, exp_cnt);
            check($sformatf("wrap_int%0d", k), {31'b0, TIMER_INT}, (k >= 19) ? 32'h1 : 32'h0);
        end

        // ---- collision: W1C on the same edge as a new match ----
        do_reset();
        ahb_write(4'h8, 3'd2, 32'h3);
        ahb_write(4'h0, 3'd2, 32'h7);
        for (int c = 0; c < 6; c++) begin
            idle();
            if (c == 4) begin
                @(negedge HCLK);
                check("coll_first_int", {31'b0, TIMER_INT}, 32'h1);
            end
        end
        bus(1'b1, 2'b10, 1'b1, 4'hC, 3'd2, 32'h0);
        bus(1'b1, 2'b10, 1'b0, 4'hC, 3'd2, 32'h1);
        idle();
        @(negedge HCLK);
        check("coll_match_kept", HRDATA, 32'h1);
        check("coll_int_kept", {31'b0, TIMER_INT}, 32'h1);
        bus(1'b1, 2'b10, 1'b1, 4'hC, 3'd2, 32'h0);
        bus(1'b1, 2'b10, 1'b0, 4'hC, 3'd2, 32'h1);
        idle();
        @(negedge HCLK);
        check("coll_clear_alone", HRDATA, 32'h0);

        // ---- collision: COUNT write on a tick edge ----
        do_reset();
        ahb_write(4'h0, 3'd2, 32'h1);
        bus(1'b1, 2'b10, 1'b1, 4'h4, 3'd2, 32'h0);
        bus(1'b1, 2'b10, 1'b0, 4'h4, 3'd2, 32'h100);
        bus(1'b1, 2'b10, 1'b0, 4'h4, 3'd2, 32'h0);
        @(negedge HCLK);
        check("cwr_override", HRDATA, 32'h100);
        idle();
        @(negedge HCLK);
        check("cwr_next", HRDATA, 32'h101);

        // ---- randomized traffic against the reference model ----
        do_reset();
        prev_w = 1'b0;
        prev_idx = 0;
        for (int i = 0; i < 3000; i++) begin
            logic       sel, wr;
            logic [1:0] tr;
            logic [2:0] sz;
            logic [1:0] off;
            int         idx;
            sel = ($urandom_range(0, 3) != 0);
            tr  = 2'($urandom_range(0, 3));
            wr  = 1'($urandom_range(0, 1));
            idx = $urandom_range(0, 3);
            sz  = 3'($urandom_range(0, 2));
            off = (sz == 3'd0) ? 2'($urandom_range(0, 3)) :
                  (sz == 3'd1) ? 2'(2 * $urandom_range(0, 1)) : 2'd0;
            if (!prev_w)            wd = $urandom;
            else if (prev_idx == 0) wd = $urandom & 32'hFFFF_03FF;
            else if (prev_idx == 3) wd = $urandom;
            else                    wd = $urandom_range(0, 24);
            addr_hi = 28'($urandom);
            bus(sel, tr, wr, {2'(idx), off}, sz, wd);
            @(negedge HCLK);
            check("rand_hrdata", HRDATA, m_rdata());
            check("rand_int", {31'b0, TIMER_INT}, {31'b0, m_match && m_ctrl[2]});
            check("rand_resp", {30'b0, HREADY, HRESP}, 32'h2);
            prev_w = sel && tr[1] && wr;
            prev_idx = idx;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
